// File: rtl/led_matrix_ayla_lin.sv
// 8x8 single-colour LED matrix core: pixel-write frame buffer plus registered row scan.
// Define LED_MATRIX_BLANK_EN to blank both outputs for the first BLANK_CYCLES of each row.
module led_matrix_ayla_lin #(
   parameter int unsigned SCAN_DIV_W   = 8,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // fb_q[r][c]: row r, column c
   logic [7:0][7:0]       fb_q, fb_d;
   logic [SCAN_DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]            row_q, row_d;
   logic [7:0]            uo_q, uo_d;
   logic [7:0]            uio_q, uio_d;

   logic                  wr_en;
   logic                  wr_val;
   logic [2:0]            wr_row;
   logic [2:0]            wr_col;
   logic                  cnt_last;
   logic                  blank;
   logic                  unused_uio;

   assign wr_en    = ui_in[7];
   assign wr_val   = ui_in[6];
   assign wr_row   = ui_in[5:3];
   assign wr_col   = ui_in[2:0];
   assign cnt_last = &cnt_q;

   assign unused_uio = ^uio_in;

`ifdef LED_MATRIX_BLANK_EN
   localparam logic [SCAN_DIV_W-1:0] BLANK_LIM = SCAN_DIV_W'(BLANK_CYCLES);
   assign blank = (cnt_q < BLANK_LIM);
`else
   logic unused_blank_cfg;
   assign unused_blank_cfg = ^(32'(BLANK_CYCLES));
   assign blank = 1'b0;
`endif

   always_comb begin
      fb_d  = fb_q;
      cnt_d = cnt_q;
      row_d = row_q;
      uo_d  = '0;
      uio_d = '0;
      if (ena) begin
         if (wr_en) begin
            fb_d[wr_row][wr_col] = wr_val;
         end
         cnt_d = cnt_q + SCAN_DIV_W'(1);
         if (cnt_last) begin
            row_d = row_q + 3'd1;
         end
         // outputs follow the pre-edge row and frame buffer
         if (!blank) begin
            uio_d = 8'b1 << row_q;
            uo_d  = fb_q[row_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fb_q  <= '0;
         cnt_q <= '0;
         row_q <= '0;
         uo_q  <= '0;
         uio_q <= '0;
      end else begin
         fb_q  <= fb_d;
         cnt_q <= cnt_d;
         row_q <= row_d;
         uo_q  <= uo_d;
         uio_q <= uio_d;
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = uio_q;
   assign uio_oe  = '1;

endmodule

// File: tb/tb_led_matrix_ayla_lin.sv
// Directed bench for led_matrix_ayla_lin at SCAN_DIV_W=2, BLANK_CYCLES=1 (4-cycle rows).
module tb_led_matrix_ayla_lin;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

`ifdef LED_MATRIX_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;   // enabled edges since reset release

   led_matrix_ayla_lin #(
      .SCAN_DIV_W  (2),
      .BLANK_CYCLES(1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output after enabled edge kk: pre-edge cnt = (kk-1)%4, row = ((kk-1)/4)%8
   function automatic logic [7:0] gate(input int kk, input logic [7:0] v);
      if (BLANK && (((kk - 1) % 4) < 1)) return 8'h00;
      return v;
   endfunction

   function automatic logic [7:0] exp_uio(input int kk);
      logic [7:0] one;
      one = 8'h01;
      return gate(kk, one << (((kk - 1) / 4) % 8));
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic tick(input logic [7:0] ui);
      ui_in = ui;
      @(posedge clk);
      #1;
      k++;
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h5A;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hFF);

      rst = 1'b0;
      k   = 0;

      // one full frame plus the wrap back into row 0
      for (int i = 0; i < 33; i++) begin
         tick(8'h00);
         chk("scan_uio", uio_out, exp_uio(k));
         chk("scan_uo", uo_out, 8'h00);
      end

      tick(8'hC5);                               // k=34, row 0
      chk("wr_before", uo_out, 8'h00);
      tick(8'hC0);                               // k=35
      chk("wr_c5", uo_out, gate(k, 8'h20));
      tick(8'h00);                               // k=36
      chk("wr_c5_c0", uo_out, 8'h21);
      chk("wr_row0", uio_out, 8'h01);

      while (k < 63) tick(8'h00);
      tick(8'h85);                               // k=64: write as scan enters row 0
      chk("row7_uio", uio_out, 8'h80);
      chk("row7_uo", uo_out, 8'h00);
      tick(8'h00);                               // k=65
      chk("clr_first_uo", uo_out, gate(k, 8'h01));
      chk("clr_first_uio", uio_out, exp_uio(k));
      tick(8'h00);                               // k=66
      chk("clr_uo", uo_out, 8'h01);

      while (k < 78) tick(8'h00);
      chk("pre_dis_uio", uio_out, 8'h08);

      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ui_in = 8'hFF;
         @(posedge clk);
         #1;
         chk("dis_uo", uo_out, 8'h00);
         chk("dis_uio", uio_out, 8'h00);
      end
      ena = 1'b1;

      tick(8'h00);                               // k=79, row 3 cnt 2
      chk("res_uio_c2", uio_out, 8'h08);
      chk("res_uo", uo_out, 8'h00);
      tick(8'h00);                               // k=80
      chk("res_uio_c3", uio_out, 8'h08);
      tick(8'h00);                               // k=81, row 4 cnt 0
      chk("res_row4a", uio_out, exp_uio(k));
      tick(8'h00);
      chk("res_row4b", uio_out, 8'h10);

      while (k < 93) tick(8'h00);
      tick(8'h00);                               // k=94, row 7
      chk("nowr_uio", uio_out, 8'h80);
      chk("nowr_uo", uo_out, 8'h00);

      for (int c = 0; c < 8; c++) tick(8'hF0 | 8'(c));

      while (k < 121) tick(8'h00);
      tick(8'h00);                               // k=122, row 6 cnt 1
      chk("row6_uio", uio_out, 8'h40);
      chk("row6_uo", uo_out, 8'hFF);

      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_uo", uo_out, 8'h00);
      chk("mrst_uio", uio_out, 8'h00);
      chk("mrst_oe", uio_oe, 8'hFF);
      rst = 1'b0;
      k   = 0;

      tick(8'h00);
      chk("post_rst_uio", uio_out, exp_uio(k));
      while (k < 26) tick(8'h00);
      chk("post_row6_uio", uio_out, 8'h40);
      chk("post_row6_uo", uo_out, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
